bus_decoder_ws: RTL

// - Parametrised successor to the fixed CPU address decoder. Decodes the CPU
//   bus into NUM_SLAVES one-hot enables and sequences each access.
// - Each access completes through a per-slave wait-state counter or through a

---
 rtl/bus_decoder_ws.sv | 137 +++++++++++++
 1 files changed

// File: rtl/bus_decoder_ws.sv
// CPU bus address decoder with per-slave wait-state or ready-handshake sequencing.
// Unmapped and timed-out accesses complete with ERR_DATA and latch a sticky error.
module bus_decoder_ws #(
    parameter int                        ADDR_WIDTH  = 25,
    parameter int                        HIGH_BIT    = 24,
    parameter int                        SEL_HI      = 19,
    parameter int                        SEL_LO      = 16,
    parameter int                        NUM_SLAVES  = 10,
    parameter logic [4*NUM_SLAVES-1:0]   WAIT_STATES = '0,
    parameter int                        TIMEOUT     = 255,
    parameter logic [31:0]               ERR_DATA    = 32'hDEADBEEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ADDR_WIDTH-1:0]        cpu_address,
    input  logic                         cpu_mem_valid,
    input  logic [3:0]                   cpu_wstrb,
    output logic                         cpu_mem_ready,
    output logic [31:0]                  cpu_rdata,
    output logic [NUM_SLAVES-1:0]        slave_en,
    output logic [NUM_SLAVES-1:0]        slave_write_en,
    output logic [3:0]                   slave_wstrb,
    input  logic [NUM_SLAVES-1:0]        slave_ready,
    input  logic [32*NUM_SLAVES-1:0]     slave_rdata,
    output logic                         bus_error,
    output logic [ADDR_WIDTH-1:0]        err_address,
    input  logic                         err_clear
);

    localparam int          IW     = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int          SW     = SEL_HI - SEL_LO + 1;
    localparam logic [15:0] TO_LIM = 16'(TIMEOUT);

    typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_DONE, S_ERROR, S_RECOVER} state_t;

    state_t                  state, state_n;
    logic [IW-1:0]           idx_q, dec_idx, idx_sel;
    logic                    dec_hit;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [15:0]             cnt;
    logic [3:0]              ws_cur;
    logic                    handshake;
    logic [SW-1:0]           sel;
    logic [31:0]             sel_rdata;
    logic                    sel_ready;
    logic [NUM_SLAVES-1:0]   en_n;
    logic [3:0]              wstrb_sel;

    assign sel       = cpu_address[SEL_HI:SEL_LO];
    assign ws_cur    = WAIT_STATES[{idx_q, 2'b00} +: 4];
    assign handshake = (ws_cur == 4'hF);
    assign sel_rdata = slave_rdata[{idx_q, 5'b00000} +: 32];
    assign sel_ready = slave_ready[idx_q];

    always_comb begin
        dec_idx = '0;
        dec_hit = 1'b0;
        if (cpu_address[HIGH_BIT]) begin
            dec_idx = IW'(NUM_SLAVES - 1);
            dec_hit = 1'b1;
        end else if (int'(sel) < NUM_SLAVES - 1) begin
            dec_idx = IW'(sel);
            dec_hit = 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:    if (cpu_mem_valid) state_n = dec_hit ? S_ACCESS : S_ERROR;
            S_ACCESS: begin
                if (handshake) begin
                    if (sel_ready)          state_n = S_DONE;
                    else if (cnt >= TO_LIM) state_n = S_ERROR;
                end else if (cnt == {12'b0, ws_cur}) begin
                    state_n = S_DONE;
                end
            end
            S_DONE:    state_n = S_RECOVER;
            S_ERROR:   state_n = S_RECOVER;
            S_RECOVER: state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    // Enables are registered off the next state so they rise on ACCESS entry
    // and fall on the same edge that leaves ACCESS.
    always_comb begin
        idx_sel   = (state == S_IDLE) ? dec_idx : idx_q;
        wstrb_sel = (state == S_IDLE) ? cpu_wstrb : slave_wstrb;
        en_n      = '0;
        if (state_n == S_ACCESS) en_n[idx_sel] = 1'b1;
    end

    assign cpu_mem_ready = (state == S_DONE) || (state == S_ERROR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            idx_q          <= '0;
            addr_q         <= '0;
            cnt            <= '0;
            cpu_rdata      <= '0;
            slave_en       <= '0;
            slave_write_en <= '0;
            slave_wstrb    <= '0;
            bus_error      <= 1'b0;
            err_address    <= '0;
        end else begin
            state          <= state_n;
            slave_en       <= en_n;
            slave_write_en <= en_n & {NUM_SLAVES{wstrb_sel != 4'b0}};

            if (state == S_IDLE && cpu_mem_valid) begin
                idx_q       <= dec_idx;
                addr_q      <= cpu_address;
                slave_wstrb <= cpu_wstrb;
                cnt         <= '0;
            end else if (state == S_ACCESS && cnt != 16'hFFFF) begin
                cnt <= cnt + 16'd1;
            end

            if (state == S_ACCESS && state_n == S_DONE) cpu_rdata <= sel_rdata;

            // Error set takes priority over a same-cycle clear.
            if (state_n == S_ERROR) begin
                cpu_rdata <= ERR_DATA;
                bus_error <= 1'b1;
                if (!bus_error)
                    err_address <= (state == S_IDLE) ? cpu_address : addr_q;
            end else if (err_clear) begin
                bus_error <= 1'b0;
            end
        end
    end

endmodule
